// File: rtl/key_led_top.sv
// Push-button LED toggle: debounces an active-low key and flips the LED once per accepted press.
// Define KEY_SYNC_EN to add a two-flop synchronizer on the raw key input (production setting).

module key_debounce #(
  parameter int DELAY_10MS = 500000
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic key,
  output logic press
);

  localparam int CNT_W = $clog2(DELAY_10MS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DELAY_10MS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_10MS - 1);

  logic             key_s;
  logic [CNT_W-1:0] cnt;

  // Saturating increment keeps a held key from ever re-reaching CNT_LAST.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c < CNT_MAX) return c + 1'b1;
    return c;
  endfunction

`ifdef KEY_SYNC_EN
  logic key_p0;
  logic key_p1;

  // Synchronizer stages; reset to the released level so reset never looks like a press.
  always_ff @(posedge sclk) begin
    if (s_rst_n) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= key;
      key_p1 <= key_p0;
    end
  end

  assign key_s = key_p1;
`else
  assign key_s = key;
`endif

  // Debounce counter: any high sample restarts the low-run count.
  always_ff @(posedge sclk) begin
    if (s_rst_n)
      cnt <= '0;
    else if (key_s)
      cnt <= '0;
    else
      cnt <= sat_inc(cnt);
  end

  assign press = ~key_s && (cnt == CNT_LAST);

endmodule

module key_led_top #(
  parameter int DELAY_10MS = 500000
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic key,
  output logic led
);

  logic press;

  key_debounce #(
    .DELAY_10MS(DELAY_10MS)
  ) u0_key_debounce_inst (
    .sclk   (sclk),
    .s_rst_n(s_rst_n),
    .key    (key),
    .press  (press)
  );

  // LED toggle register
  always_ff @(posedge sclk) begin
    if (s_rst_n)
      led <= 1'b0;
    else if (press)
      led <= ~led;
  end

endmodule

// File: tb/tb_key_led_top.sv
// Bench for key_led_top: randomized key bounce checked against a low-run-length reference model.

module tb_key_led_top;

  localparam int D = 110;
`ifdef KEY_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic sclk    = 1'b0;
  logic s_rst_n = 1'b1;
  logic key     = 1'b1;
  logic led;

  always #5 sclk = ~sclk;

  key_led_top #(
    .DELAY_10MS(D)
  ) dut (
    .sclk   (sclk),
    .s_rst_n(s_rst_n),
    .key    (key),
    .led    (led)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state: key history, length of current low run seen by the counter
  logic k1 = 1'b1, k2 = 1'b1, prev_key = 1'b1, prev_led = 1'b0, m_led = 1'b0;
  int   run = 0;
  int   edge_no = 0;
  int   low_start = 0;
  int   obs_tog = 0;
  int   last_tog_edge = -1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_no);
    end
  endtask

  task automatic step(input logic k, input logic r);
    logic ks;
    @(negedge sclk);
    key     = k;
    s_rst_n = r;
    @(posedge sclk);
    edge_no++;
    if (k == 1'b0 && prev_key == 1'b1) low_start = edge_no;
    prev_key = k;
    if (r) begin
      k1 = 1'b1; k2 = 1'b1; run = 0; m_led = 1'b0;
    end else begin
      ks = (SYNC_LAT == 2) ? k2 : k;
      if (ks == 1'b0) run++;
      else run = 0;
      if (run == D) m_led = ~m_led;
      k2 = k1;
      k1 = k;
    end
    #1;
    chk("led", {31'b0, led}, {31'b0, m_led});
    if (led !== prev_led) begin
      obs_tog++;
      last_tog_edge = edge_no;
    end
    prev_led = led;
  endtask

  task automatic press_release(input string tag, input logic exp_led);
    int base;
    base = obs_tog;
    repeat (100) step(1'b1, 1'b0);
    repeat (100) step(1'($urandom_range(0, 1)), 1'b0);
    repeat (300) step(1'b0, 1'b0);
    chk({tag, "_tog"}, obs_tog - base, 1);
    chk({tag, "_lat"}, last_tog_edge - low_start + 1, D + SYNC_LAT);
    repeat (100) step(1'($urandom_range(0, 1)), 1'b0);
    repeat (50) step(1'b1, 1'b0);
    chk({tag, "_rel_tog"}, obs_tog - base, 1);
    chk({tag, "_led"}, {31'b0, led}, {31'b0, exp_led});
  endtask

  task automatic low_pulse(input int len);
    repeat (len) step(1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b0);
  endtask

  initial begin
    int base;
    int rel;

    // reset with key released
    repeat (10) begin
      step(1'b1, 1'b1);
      chk("rst_led", {31'b0, led}, 32'd0);
    end
    base = obs_tog;
    repeat (50) step(1'b1, 1'b0);
    chk("idle_tog", obs_tog - base, 0);
    chk("idle_led", {31'b0, led}, 32'd0);

    press_release("press1", 1'b1);
    press_release("press2", 1'b0);

    // held key: one toggle, counter saturated
    base = obs_tog;
    repeat (10000) step(1'b0, 1'b0);
    chk("held_tog", obs_tog - base, 1);
    chk("held_cnt", 32'(dut.u0_key_debounce_inst.cnt), D);
    repeat (20) step(1'b1, 1'b0);
    chk("held_led", {31'b0, led}, 32'd1);

    // threshold: one sample short, then exactly enough
    base = obs_tog;
    low_pulse(D - 1);
    chk("short_tog", obs_tog - base, 0);
    low_pulse(D);
    chk("exact_tog", obs_tog - base, 1);
    chk("exact_lat", last_tog_edge - low_start + 1, D + SYNC_LAT);
    chk("exact_led", {31'b0, led}, 32'd0);
    low_pulse(D);
    chk("pre_rst_led", {31'b0, led}, 32'd1);

    // reset in the middle of a count with the key held low
    repeat (80 + SYNC_LAT) step(1'b0, 1'b0);
    chk("mid_cnt", 32'(dut.u0_key_debounce_inst.cnt), 80);
    repeat (2) step(1'b0, 1'b1);
    chk("mid_rst_led", {31'b0, led}, 32'd0);
    chk("mid_rst_cnt", 32'(dut.u0_key_debounce_inst.cnt), 0);
    rel  = edge_no;
    base = obs_tog;
    repeat (400) step(1'b0, 1'b0);
    chk("mid_tog", obs_tog - base, 1);
    chk("mid_lat", last_tog_edge - rel, D + SYNC_LAT);
    chk("mid_led", {31'b0, led}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_led_top.md
# key_led_top

Push-button LED toggle block. Debounces one active-low mechanical key input and flips one LED output once per accepted press. Releases, bounce bursts and held keys never cause extra toggles. It is the top level of the key/LED demo: the board key pin feeds it directly, and the LED pin is driven directly from it.

## Interface
Parameters:
- `DELAY_10MS`, default 500000 (10 ms at 50 MHz): number of consecutive low samples required to accept a press.
  - Legal range is ≥ 2.
  - Passed unchanged to the debounce sub-instance `u0_key_debounce_inst`, whose parameter is also named `DELAY_10MS` and must be overridable hierarchically.

Ports:
- `sclk`  in  1  system clock; all logic is on its rising edge.
- `s_rst_n`  in  1  reset.
  - One clock; reset is synchronous and active-high.
  - The codebase port name is kept; 1 = reset asserted.
- `key`  in  1  raw push-button level. 0 = pressed, 1 = released. Asynchronous to `sclk` and may bounce.
- `led`  out  1  LED drive. 1 = lit.

## Operation
- Structure: sub-module `key_debounce` (instance `u0_key_debounce_inst`) plus an LED toggle register in the top.
- Input stage produces `key_s`:
  - With `KEY_SYNC_EN` defined, `key_s` is `key` through a two-flop synchronizer.
  - Without it, `key_s` is `key` used directly.
- Debounce counter `cnt`:
  - Width is clog2(`DELAY_10MS`+1).
  - On each edge: if `key_s`==1, `cnt` <= 0.
  - Else, if `cnt` < `DELAY_10MS`, `cnt` <= `cnt`+1.
  - Else, hold: `cnt` saturates at `DELAY_10MS`.
- Press event:
  - Asserted on the single edge where `key_s`==0 and `cnt`==`DELAY_10MS`-1, i.e. the edge where `cnt` becomes `DELAY_10MS`.
  - Saturation guarantees exactly one event per continuous low run.
- LED: on a press event, `led` <= ~`led`; otherwise `led` holds.
- Bounce handling:
  - Any high sample restarts the count from 0.
  - A low run shorter than `DELAY_10MS` samples produces no event.
  - Release bounce can only clear `cnt`, never toggle `led`.
- Reset values: `cnt`=0, `led`=0, synchronizer flops=1 (released).
- Reset mid-operation:
  - The count is discarded.
  - If `key` stays low across reset deassertion, a fresh full count of `DELAY_10MS` low samples is required, and then exactly one toggle occurs.
- No other outputs; no combinational path from `key` to `led`.

## Timing
- Let edge E0 be the first rising edge at which `key_s`==0 after it was 1 (or after reset).
- If `key_s` stays 0 through edge E0+`DELAY_10MS`-1, then `led` changes value at that edge.
- Latency from `key_s` going low to the `led` change is `DELAY_10MS` cycles.
- Added latency from `key`:
  - With `KEY_SYNC_EN`: +2 cycles from a `key` change to the corresponding `key_s` change.
  - Without it: 0.
- `led` changes at most once per continuous low run of `key_s`, regardless of run length.
- Minimum spacing between two toggles is `DELAY_10MS`+1 cycles: one high sample plus a full low count.
- Reset has priority over all counting and toggling on the same edge.

## Configuration
- `KEY_SYNC_EN`:
  - Defined: two-stage synchronizer on `key` (both flops reset to 1). Adds 2 cycles of latency and is metastability-safe. This is the production setting.
  - Undefined: `key` is sampled directly by the debounce counter, with zero added latency. For use only when `key` is already synchronous to `sclk`.
- Debounce and toggle behaviour are otherwise identical in both builds.

## Test plan
All scenarios use `DELAY_10MS`=110, `KEY_SYNC_EN` defined, and a 10 ns clock.

- Reset: hold reset 10 cycles with `key`=1 → `led`=0 during and after reset; no toggle while `key` stays 1.
- Realistic press, then release:
  - Stimulus: `key`=1 for 100 cycles, random bounce for 100 cycles, 0 for 300 cycles, random bounce for 100 cycles, then 1.
  - Required: `led` goes 0→1 exactly once, exactly 112 cycles after the start of the final continuous low run of `key`.
  - Required: no further change through the release bounce.
- Second identical press → `led` returns to 0; exactly one toggle.
- Threshold:
  - A 109-cycle low pulse (after sync) → no toggle.
  - A subsequent 110-cycle low pulse → exactly one toggle on its last sampled low edge.
- Held key: `key`=0 for 10000 cycles → exactly one toggle; `cnt` saturates at 110.
- Reset mid-count:
  - Stimulus: assert reset at count 80 while `key`=0, then deassert with `key` still 0.
  - Required: `led`=0 immediately after reset.
  - Required: `led` toggles 110+2 cycles after deassertion, and only once.
